compute_accumulator_unit: RTL and testbench

Parametrised, clocked accumulator ALU: a bitwise/arithmetic/rotate unit that combines a held accumulator with an operand under a req/done handshake. Each completed transaction commits its result back into the accumulator, so a sequence of requests chains operations. It extends the 4-bit, four-opcode computation device with a configurable width, arithmetic ops with flags, a multi-cycle rotate, an explicit load, and abort handling.

---
 rtl/compute_accumulator_unit_pkg.sv | 21 ++
 rtl/compute_accumulator_unit_if.sv | 26 ++
 rtl/compute_accumulator_unit_alu_core.sv | 46 ++++
 rtl/compute_accumulator_unit.sv | 154 +++++++++++++++
 tb/tb_compute_accumulator_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/compute_accumulator_unit_pkg.sv
// Shared types for the compute accumulator unit: opcode encoding and FSM states.
package compute_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_NAND = 3'b001,
    OP_NOR  = 3'b010,
    OP_XOR  = 3'b011,
    OP_OR   = 3'b100,
    OP_ADD  = 3'b101,
    OP_SUB  = 3'b110,
    OP_ROTL = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_HOLD  = 2'b10
  } state_e;

endpackage

// File: rtl/compute_accumulator_unit_if.sv
// Request/result bundle between a requester (master) and the accumulator unit (slave).
interface compute_accumulator_unit_if #(parameter int WIDTH = 4);

  logic             load;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [2:0]       opcode;
  logic             req;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] acc;
  logic             done;
  logic             busy;
  logic             zero;
  logic             carry;

  modport master (
    output load, x, y, opcode, req,
    input  result, acc, done, busy, zero, carry
  );

  modport slave (
    input  load, x, y, opcode, req,
    output result, acc, done, busy, zero, carry
  );

endinterface

// File: rtl/compute_accumulator_unit_alu_core.sv
// Combinational logic/arithmetic core; rotate is sequenced by the top level.
module compute_alu_core
  import compute_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] y,
  input  opcode_e          opcode,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;

  // Top bit of the widened difference is set exactly when acc < y (borrow).
  assign sum_s  = {1'b0, acc} + {1'b0, y};
  assign diff_s = {1'b0, acc} - {1'b0, y};

  // Operation select.
  always_comb begin
    value = {WIDTH{1'b0}};
    carry = 1'b0;
    case (opcode)
      OP_AND:  value = acc & y;
      OP_NAND: value = ~(acc & y);
      OP_NOR:  value = ~(acc | y);
      OP_XOR:  value = acc ^ y;
      OP_OR:   value = acc | y;
      OP_ADD: begin
        value = sum_s[WIDTH-1:0];
        carry = sum_s[WIDTH];
      end
      OP_SUB: begin
        value = diff_s[WIDTH-1:0];
        carry = diff_s[WIDTH];
      end
      default: begin
        value = {WIDTH{1'b0}};
        carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/compute_accumulator_unit.sv
// Accumulator ALU: req/done handshake, commit on req drop, multi-cycle rotate with abort.
module compute_accumulator_unit
  import compute_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  compute_accumulator_unit_if.slave   bus
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   acc_nxt_s;
  logic [WIDTH-1:0]   result_r;
  logic [WIDTH-1:0]   result_nxt_s;
  logic               zero_r;
  logic               zero_nxt_s;
  logic               carry_r;
  logic               carry_nxt_s;
  logic               done_r;
  logic               busy_r;
  logic [SHAMT_W-1:0] count_r;
  logic [SHAMT_W-1:0] count_nxt_s;
  logic [SHAMT_W-1:0] amount_s;
  logic [WIDTH-1:0]   alu_value_s;
  logic               alu_carry_s;
  opcode_e            opcode_s;

  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  assign opcode_s = opcode_e'(bus.opcode);
  assign amount_s = bus.y[SHAMT_W-1:0];

  compute_alu_core #(.WIDTH(WIDTH)) u_alu (
    .acc    (acc_r),
    .y      (bus.y),
    .opcode (opcode_s),
    .value  (alu_value_s),
    .carry  (alu_carry_s)
  );

  // Next-state and datapath update. The first rotate step happens on the
  // request edge, so a rotate by k finishes after k edges in total; count_r
  // holds the steps still outstanding once in SHIFT.
  always_comb begin
    state_nxt_s  = state_r;
    acc_nxt_s    = acc_r;
    result_nxt_s = result_r;
    zero_nxt_s   = zero_r;
    carry_nxt_s  = carry_r;
    count_nxt_s  = count_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.load) begin
          acc_nxt_s    = bus.x;
          result_nxt_s = bus.x;
          zero_nxt_s   = (bus.x == {WIDTH{1'b0}});
          carry_nxt_s  = 1'b0;
          state_nxt_s  = ST_IDLE;
        end else if (bus.req) begin
          if (opcode_s != OP_ROTL) begin
            result_nxt_s = alu_value_s;
            carry_nxt_s  = alu_carry_s;
            zero_nxt_s   = (alu_value_s == {WIDTH{1'b0}});
            state_nxt_s  = ST_HOLD;
          end else if (amount_s == {SHAMT_W{1'b0}}) begin
            result_nxt_s = acc_r;
            carry_nxt_s  = 1'b0;
            zero_nxt_s   = (acc_r == {WIDTH{1'b0}});
            state_nxt_s  = ST_HOLD;
          end else begin
            result_nxt_s = rotl1(acc_r);
            carry_nxt_s  = 1'b0;
            zero_nxt_s   = (acc_r == {WIDTH{1'b0}});
            count_nxt_s  = amount_s - SHAMT_W'(1);
            if (amount_s == SHAMT_W'(1)) begin
              state_nxt_s = ST_HOLD;
            end else begin
              state_nxt_s = ST_SHIFT;
            end
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bus.req) begin
          result_nxt_s = rotl1(result_r);
          zero_nxt_s   = (result_r == {WIDTH{1'b0}});
          count_nxt_s  = count_r - SHAMT_W'(1);
          if (count_r == SHAMT_W'(1)) begin
            state_nxt_s = ST_HOLD;
          end else begin
            state_nxt_s = ST_SHIFT;
          end
        end else begin
          result_nxt_s = acc_r;
          zero_nxt_s   = (acc_r == {WIDTH{1'b0}});
          carry_nxt_s  = 1'b0;
          count_nxt_s  = {SHAMT_W{1'b0}};
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (bus.req) begin
          state_nxt_s = ST_HOLD;
        end else begin
          acc_nxt_s   = result_r;
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      acc_r    <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      zero_r   <= 1'b0;
      carry_r  <= 1'b0;
      count_r  <= {SHAMT_W{1'b0}};
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      acc_r    <= acc_nxt_s;
      result_r <= result_nxt_s;
      zero_r   <= zero_nxt_s;
      carry_r  <= carry_nxt_s;
      count_r  <= count_nxt_s;
      done_r   <= (state_nxt_s == ST_HOLD);
      busy_r   <= (state_nxt_s == ST_SHIFT);
    end
  end

  assign bus.result = result_r;
  assign bus.acc    = acc_r;
  assign bus.done   = done_r;
  assign bus.busy   = busy_r;
  assign bus.zero   = zero_r;
  assign bus.carry  = carry_r;

endmodule

// File: tb/tb_compute_accumulator_unit.sv
// Directed bench for compute_accumulator_unit (WIDTH=4): vector table plus handshake corner sequences.
module tb_compute_accumulator_unit;
  import compute_pkg::*;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;

  compute_accumulator_unit_if #(.WIDTH(WIDTH)) bus ();

  compute_accumulator_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] x;
    logic [2:0] op;
    logic [3:0] y;
    logic [3:0] res;
    logic       c;
    logic       z;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    bus.load = 1'b1;
    bus.x    = v;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic start(input logic [2:0] op, input logic [3:0] yv);
    bus.req    = 1'b1;
    bus.opcode = op;
    bus.y      = yv;
  endtask

  initial begin
    vecs[0]  = '{4'hC, 3'b000, 4'hA, 4'h8, 1'b0, 1'b0};
    vecs[1]  = '{4'hC, 3'b001, 4'hA, 4'h7, 1'b0, 1'b0};
    vecs[2]  = '{4'hC, 3'b010, 4'hA, 4'h1, 1'b0, 1'b0};
    vecs[3]  = '{4'hC, 3'b011, 4'hA, 4'h6, 1'b0, 1'b0};
    vecs[4]  = '{4'hC, 3'b100, 4'hA, 4'hE, 1'b0, 1'b0};
    vecs[5]  = '{4'hF, 3'b101, 4'h1, 4'h0, 1'b1, 1'b1};
    vecs[6]  = '{4'h3, 3'b110, 4'h5, 4'hE, 1'b1, 1'b0};
    vecs[7]  = '{4'h7, 3'b101, 4'h8, 4'hF, 1'b0, 1'b0};
    vecs[8]  = '{4'hA, 3'b110, 4'hA, 4'h0, 1'b0, 1'b1};
    vecs[9]  = '{4'h5, 3'b000, 4'hA, 4'h0, 1'b0, 1'b1};
    vecs[10] = '{4'hC, 3'b111, 4'h4, 4'hC, 1'b0, 1'b0};
    vecs[11] = '{4'h9, 3'b111, 4'h1, 4'h3, 1'b0, 1'b0};

    reset      = 1'b0;
    bus.load   = 1'b0;
    bus.req    = 1'b0;
    bus.x      = 4'h0;
    bus.y      = 4'h0;
    bus.opcode = 3'b000;
    #12;
    chk("rst_result", {4'h0, bus.result}, 8'h00);
    chk("rst_acc",    {4'h0, bus.acc},    8'h00);
    chk("rst_flags",  {4'h0, bus.done, bus.busy, bus.zero, bus.carry}, 8'h00);
    reset = 1'b1;
    tick();

    // Single-cycle ops and zero/one-step rotates from the table.
    for (int i = 0; i < 12; i++) begin
      do_load(vecs[i].x);
      start(vecs[i].op, vecs[i].y);
      tick();
      chk($sformatf("v%0d_result", i), {4'h0, bus.result}, {4'h0, vecs[i].res});
      chk($sformatf("v%0d_carry", i),  {7'h0, bus.carry},  {7'h0, vecs[i].c});
      chk($sformatf("v%0d_zero", i),   {7'h0, bus.zero},   {7'h0, vecs[i].z});
      chk($sformatf("v%0d_done", i),   {6'h0, bus.done, bus.busy}, 8'h02);
      bus.req = 1'b0;
      tick();
      chk($sformatf("v%0d_commit", i), {3'h0, bus.done, bus.acc}, {4'h0, vecs[i].res});
    end

    // Logic chain: AND then XOR on the committed accumulator.
    do_load(4'hC);
    start(3'b000, 4'hA);
    tick();
    chk("chain_and", {3'h0, bus.done, bus.result}, 8'h18);
    bus.req = 1'b0;
    tick();
    chk("chain_acc", {4'h0, bus.acc}, 8'h08);
    start(3'b011, 4'hF);
    tick();
    chk("chain_xor", {3'h0, bus.done, bus.result}, 8'h17);
    bus.req = 1'b0;
    tick();
    chk("chain_acc2", {4'h0, bus.acc}, 8'h07);

    // Rotate by 3 with y/opcode changed mid-shift, then rotate by 4 (amount 0).
    do_load(4'h9);
    start(3'b111, 4'h3);
    tick();
    chk("rot_e1", {6'h0, bus.done, bus.busy}, 8'h01);
    bus.y      = 4'h1;
    bus.opcode = 3'b000;
    tick();
    chk("rot_e2", {6'h0, bus.done, bus.busy}, 8'h01);
    tick();
    chk("rot_e3", {2'h0, bus.done, bus.busy, bus.result}, 8'h2C);
    bus.req = 1'b0;
    tick();
    chk("rot_commit", {3'h0, bus.done, bus.acc}, 8'h0C);
    start(3'b111, 4'h4);
    tick();
    chk("rot0", {3'h0, bus.done, bus.result}, 8'h1C);
    bus.req = 1'b0;
    tick();

    // Abort mid-rotate.
    do_load(4'h9);
    start(3'b111, 4'h3);
    tick();
    chk("abort_busy", {7'h0, bus.busy}, 8'h01);
    bus.req = 1'b0;
    tick();
    chk("abort_result", {4'h0, bus.result}, 8'h09);
    chk("abort_acc",    {4'h0, bus.acc},    8'h09);
    chk("abort_flags",  {4'h0, bus.done, bus.busy, bus.zero, bus.carry}, 8'h00);
    tick();
    chk("abort_nodone", {7'h0, bus.done}, 8'h00);

    // load wins over req in IDLE.
    bus.load = 1'b1;
    bus.x    = 4'h5;
    start(3'b101, 4'h1);
    tick();
    bus.load = 1'b0;
    bus.req  = 1'b0;
    chk("prio_acc", {2'h0, bus.done, bus.busy, bus.acc}, 8'h05);
    tick();
    chk("prio_result", {3'h0, bus.done, bus.result}, 8'h05);

    // load during HOLD is ignored.
    start(3'b000, 4'hF);
    tick();
    chk("hold_done", {3'h0, bus.done, bus.result}, 8'h15);
    bus.load = 1'b1;
    bus.x    = 4'h0;
    tick();
    bus.load = 1'b0;
    chk("hold_load", {bus.acc, bus.result}, 8'h55);
    chk("hold_still", {7'h0, bus.done}, 8'h01);
    bus.req = 1'b0;
    tick();
    chk("hold_commit", {4'h0, bus.acc}, 8'h05);

    // Asynchronous reset mid-SHIFT.
    do_load(4'h9);
    start(3'b111, 4'h3);
    tick();
    chk("rst_shift_busy", {7'h0, bus.busy}, 8'h01);
    #1 reset = 1'b0;
    #1;
    chk("rst_async_data",  {bus.acc, bus.result}, 8'h00);
    chk("rst_async_flags", {4'h0, bus.done, bus.busy, bus.zero, bus.carry}, 8'h00);
    bus.req = 1'b0;
    #2 reset = 1'b1;
    tick();
    start(3'b101, 4'h3);
    tick();
    chk("post_rst_add", {3'h0, bus.done, bus.result}, 8'h13);
    chk("post_rst_acc", {4'h0, bus.acc}, 8'h00);
    bus.req = 1'b0;
    tick();
    chk("post_rst_commit", {4'h0, bus.acc}, 8'h03);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
